// File: rtl/uart_pkg.sv
// UART shared definitions: frame FSM states and line constants.
// Imported by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte-load / line-status bundle between the byte source
// (with its parity generator) and the transmit framer.
interface uart_tx_frame_if;

  logic [7:0] Tx_data;
  logic       Load_data;
  logic       Parity;
  logic       Tx_out;
  logic       Tx_busy;
  logic       Tx_done;

  modport master (
    output Tx_data,
    output Load_data,
    output Parity,
    input  Tx_out,
    input  Tx_busy,
    input  Tx_done
  );

  modport slave (
    input  Tx_data,
    input  Load_data,
    input  Parity,
    output Tx_out,
    output Tx_busy,
    output Tx_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time counter: registered one-cycle tick in the cycle
// where the count sits at CLKS_PER_BIT-1.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // tick is registered from the next count, so it lines up
  // with the cycle that holds LAST
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
    tick_d = enable && !clear && (cnt_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign bit_tick = tick_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, 8 data bits LSB-first,
// optional parity and 1-2 stop bits at CLKS_PER_BIT.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_frame_if.slave  tx
);

  localparam logic ODD_FLIP  = (PARITY_ODD != 0);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  tx_state_t state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       par_q, par_d;
  logic       stop_q, stop_d;
  logic       tx_out_q, tx_out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bit_tick;
  logic       load_ok;

  assign load_ok = (state_q == TX_IDLE) && tx.Load_data;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (load_ok),
    .enable  (state_q != TX_IDLE),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TX_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      par_q    <= 1'b0;
      stop_q   <= 1'b0;
      tx_out_q <= UART_IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      par_q    <= par_d;
      stop_q   <= stop_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    stop_d  = stop_q;
    unique case (state_q)
      TX_IDLE: begin
        if (tx.Load_data) begin
          state_d = TX_START;
          shift_d = tx.Tx_data;
          par_d   = tx.Parity ^ ODD_FLIP;
        end
      end
      TX_START: begin
        if (bit_tick) begin
          state_d = TX_DATA;
          idx_d   = '0;
        end
      end
      TX_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          stop_d  = 1'b0;
          if (idx_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
          end
        end
      end
      TX_PARITY: begin
        if (bit_tick) begin
          state_d = TX_STOP;
          stop_d  = 1'b0;
        end
      end
      TX_STOP: begin
        if (bit_tick) begin
          stop_d = 1'b1;
          if (stop_q == LAST_STOP) begin
            state_d = TX_IDLE;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // outputs are decoded from next state so they register
  // in step with the FSM
  always_comb begin
    unique case (state_d)
      TX_START:  tx_out_d = 1'b0;
      TX_DATA:   tx_out_d = shift_d[0];
      TX_PARITY: tx_out_d = par_d;
      default:   tx_out_d = UART_IDLE_LEVEL;
    endcase
    busy_d = (state_d != TX_IDLE);
    done_d = (state_q == TX_STOP) && (state_d == TX_IDLE);
  end

  assign tx.Tx_out  = tx_out_q;
  assign tx.Tx_busy = busy_q;
  assign tx.Tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame over four parameter sets.
// Frames are pushed on load and popped when a start bit appears.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int PEN  [4] = '{1, 1, 0, 1};
  localparam int PODD [4] = '{0, 1, 0, 0};
  localparam int STB  [4] = '{1, 1, 1, 2};

  typedef struct {
    int          k;
    logic [15:0] bits;
    int          nb;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] data [4];
  logic [3:0] load, par;
  logic [3:0] txo, busy, done;

  int checks = 0;
  int errors = 0;
  frame_t sb_q [$];

  uart_tx_frame_if i0 ();
  uart_tx_frame_if i1 ();
  uart_tx_frame_if i2 ();
  uart_tx_frame_if i3 ();

  assign i0.Tx_data = data[0];
  assign i0.Load_data = load[0];
  assign i0.Parity = par[0];
  assign i1.Tx_data = data[1];
  assign i1.Load_data = load[1];
  assign i1.Parity = par[1];
  assign i2.Tx_data = data[2];
  assign i2.Load_data = load[2];
  assign i2.Parity = par[2];
  assign i3.Tx_data = data[3];
  assign i3.Load_data = load[3];
  assign i3.Parity = par[3];

  assign txo  = {i3.Tx_out, i2.Tx_out, i1.Tx_out, i0.Tx_out};
  assign busy = {i3.Tx_busy, i2.Tx_busy, i1.Tx_busy, i0.Tx_busy};
  assign done = {i3.Tx_done, i2.Tx_done, i1.Tx_done, i0.Tx_done};

  uart_tx_frame #(
    .CLKS_PER_BIT(CPB), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) dut0 (.clk(clk), .rst_n(rst_n), .tx(i0));

  uart_tx_frame #(
    .CLKS_PER_BIT(CPB), .PARITY_EN(1),
    .PARITY_ODD(1), .STOP_BITS(1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .tx(i1));

  uart_tx_frame #(
    .CLKS_PER_BIT(CPB), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) dut2 (.clk(clk), .rst_n(rst_n), .tx(i2));

  uart_tx_frame #(
    .CLKS_PER_BIT(CPB), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(2)
  ) dut3 (.clk(clk), .rst_n(rst_n), .tx(i3));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t mk(input int k,
                                input logic [7:0] d,
                                input logic p);
    frame_t f;
    int n = 0;
    f.k = k;
    f.bits = '0;
    f.bits[n] = 1'b0;
    n++;
    for (int i = 0; i < 8; i++) begin
      f.bits[n] = d[i];
      n++;
    end
    if (PEN[k] != 0) begin
      f.bits[n] = p ^ (PODD[k] != 0);
      n++;
    end
    for (int i = 0; i < STB[k]; i++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nb = n;
    return f;
  endfunction

  // one-cycle load; inputs are scrambled afterwards
  task automatic send(input int k, input logic [7:0] d,
                      input bit push);
    data[k] = d;
    par[k] = ^d;
    load[k] = 1'b1;
    if (push) sb_q.push_back(mk(k, d, ^d));
    tick();
    load[k] = 1'b0;
    data[k] = ~d;
    par[k] = ~(^d);
  endtask

  task automatic check_frame(input int k, output int waited);
    frame_t f;
    waited = 0;
    while (txo[k] !== 1'b0 && waited < 100) begin
      tick();
      waited++;
    end
    if (waited >= 100) begin
      chk("start_timeout", 1, 0);
      return;
    end
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    f = sb_q.pop_front();
    chk("sb_dut", f.k, k);
    for (int i = 0; i < f.nb * CPB; i++) begin
      chk($sformatf("line_bit%0d", i / CPB), txo[k],
          f.bits[i / CPB]);
      chk("busy_in_frame", busy[k], 1);
      chk("done_in_frame", done[k], 0);
      tick();
    end
    chk("done_pulse", done[k], 1);
    chk("busy_at_done", busy[k], 0);
    chk("line_at_done", txo[k], 1);
  endtask

  int w;
  int nd;
  int bad;

  initial begin
    for (int k = 0; k < 4; k++) data[k] = 8'h00;
    load = '0;
    par = '0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      chk("rst_line", txo[k], 1);
      chk("rst_busy", busy[k], 0);
      chk("rst_done", done[k], 0);
    end
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (txo[0] !== 1'b1 || busy[0] !== 1'b0 ||
          done[0] !== 1'b0) bad++;
    end
    chk("idle_50", bad, 0);

    send(0, 8'hA5, 1);
    chk("busy_rise", busy[0], 1);
    check_frame(0, w);
    chk("start_latency", w, 0);

    send(1, 8'h07, 1);
    check_frame(1, w);
    send(2, 8'h5B, 1);
    check_frame(2, w);
    send(3, 8'hC3, 1);
    check_frame(3, w);

    fork
      begin
        send(0, 8'hA5, 1);
        repeat (10) tick();
        send(0, 8'hFF, 0);
      end
      check_frame(0, w);
    join
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done[0] === 1'b1) nd++;
    end
    chk("busy_load_done_cnt", nd, 0);
    chk("busy_load_sb", sb_q.size(), 0);

    fork
      begin
        send(0, 8'h96, 1);
        bad = 1;
        for (int i = 0; i < 200; i++) begin
          tick();
          if (done[0] === 1'b1) begin
            bad = 0;
            break;
          end
        end
        chk("b2b_done_seen", bad, 0);
        send(0, 8'h3C, 1);
      end
      begin
        check_frame(0, w);
        check_frame(0, w);
        chk("b2b_gap", w, 1);
      end
    join

    send(0, 8'hA5, 0);
    repeat (17) tick();
    chk("pre_rst_line", txo[0], 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_line", txo[0], 1);
    chk("async_rst_busy", busy[0], 0);
    chk("async_rst_done", done[0], 0);
    tick();
    tick();
    rst_n = 1'b1;
    nd = 0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done[0] === 1'b1) nd++;
      if (txo[0] !== 1'b1) bad++;
    end
    chk("rst_abandon_done", nd, 0);
    chk("rst_abandon_line", bad, 0);

    send(0, 8'h81, 1);
    check_frame(0, w);
    tick();
    chk("final_done_low", done[0], 0);
    chk("final_sb", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
